// File: rtl/ntt_pkg.sv
// Shared types and moduli for the NTT butterfly datapath.
package ntt_pkg;

    localparam int unsigned WIDTH = 23;

    typedef logic [WIDTH-1:0] coeff_t;

    localparam coeff_t Q_DILITHIUM = 23'd8380417;
    localparam coeff_t Q_KYBER     = 23'd3329;

    typedef enum logic {
        BF_CT = 1'b0,
        BF_GS = 1'b1
    } bf_mode_e;

    // Operand bundle captured by the first pipeline stage.
    typedef struct packed {
        logic     select;
        bf_mode_e mode;
        coeff_t   a;
        coeff_t   b;
        coeff_t   w;
    } bf_in_t;

    function automatic coeff_t q_of(input logic select);
        return select ? Q_KYBER : Q_DILITHIUM;
    endfunction

endpackage

// File: rtl/mod_addsub.sv
// Combinational modular add and subtract of two reduced coefficients.
module mod_addsub
    import ntt_pkg::*;
(
    input  logic [WIDTH-1:0] u_i,
    input  logic [WIDTH-1:0] v_i,
    input  logic             select_i,
    output logic [WIDTH-1:0] sum_o,
    output logic [WIDTH-1:0] diff_o
);

    localparam int unsigned SW = WIDTH + 1;

    logic [SW-1:0] q_ext;
    logic [SW-1:0] sum_full;

    assign q_ext    = SW'(q_of(select_i));
    assign sum_full = SW'(u_i) + SW'(v_i);

    assign sum_o  = (sum_full >= q_ext) ? WIDTH'(sum_full - q_ext) : WIDTH'(sum_full);
    assign diff_o = (u_i < v_i) ? WIDTH'(SW'(u_i) + q_ext - SW'(v_i)) : WIDTH'(u_i - v_i);

endmodule

// File: rtl/mod_mul.sv
// Combinational modular multiplier: p = a*b mod q, q chosen by select.
module mod_mul
    import ntt_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             select_i,
    output logic [WIDTH-1:0] p_o
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0] prod;
    logic [PW-1:0] rem;
    logic [PW-1:0] q_sh;

    // Restoring reduction: product < q * 2^WIDTH, so strip q*2^k from k=WIDTH down.
    always_comb begin
        prod = PW'(a_i) * PW'(b_i);
        rem  = prod;
        q_sh = '0;
        for (int k = WIDTH; k >= 0; k--) begin
            q_sh = PW'(q_of(select_i)) << k;
            if (rem >= q_sh) begin
                rem = rem - q_sh;
            end
        end
    end

    assign p_o = WIDTH'(rem);

endmodule

// File: rtl/ntt_butterfly.sv
// Three-stage CT/GS butterfly for Dilithium and Kyber with valid/ready on both sides.
module ntt_butterfly
    import ntt_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             select_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] w_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] y_o
);

    bf_in_t   s1_q, s1_d;
    logic     s1_v_q;

    coeff_t   s2_m_q, s2_m_d;
    coeff_t   s2_t_q, s2_t_d;
    logic     s2_sel_q;
    bf_mode_e s2_mode_q;
    logic     s2_v_q;

    coeff_t   x_q, x_d;
    coeff_t   y_q, y_d;
    logic     s3_v_q;

    logic     en1, en2, en3;
    coeff_t   pre_sum, pre_diff, mul_op, prod;
    coeff_t   post_sum, post_diff;

    // A stage may load whenever the stage it feeds is empty or moving.
    assign en3     = !s3_v_q || ready_i;
    assign en2     = !s2_v_q || en3;
    assign en1     = !s1_v_q || en2;
    assign ready_o = en1 && !rst_i;

    mod_addsub u_pre (
        .u_i      (s1_q.a),
        .v_i      (s1_q.b),
        .select_i (s1_q.select),
        .sum_o    (pre_sum),
        .diff_o   (pre_diff)
    );

    mod_mul u_mul (
        .a_i      (mul_op),
        .b_i      (s1_q.w),
        .select_i (s1_q.select),
        .p_o      (prod)
    );

    mod_addsub u_post (
        .u_i      (s2_t_q),
        .v_i      (s2_m_q),
        .select_i (s2_sel_q),
        .sum_o    (post_sum),
        .diff_o   (post_diff)
    );

    always_comb begin
        s1_d   = '{select: select_i, mode: bf_mode_e'(mode_i), a: a_i, b: b_i, w: w_i};
        mul_op = s1_q.b;
        s2_t_d = s1_q.a;
        x_d    = post_sum;
        y_d    = post_diff;
        if (s1_q.mode == BF_GS) begin
            mul_op = pre_diff;
            s2_t_d = pre_sum;
        end
        s2_m_d = prod;
        if (s2_mode_q == BF_GS) begin
            x_d = s2_t_q;
            y_d = s2_m_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q      <= '0;
            s1_v_q    <= 1'b0;
            s2_m_q    <= '0;
            s2_t_q    <= '0;
            s2_sel_q  <= 1'b0;
            s2_mode_q <= BF_CT;
            s2_v_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            s3_v_q    <= 1'b0;
        end else begin
            if (en1) begin
                s1_q   <= s1_d;
                s1_v_q <= valid_i;
            end
            if (en2) begin
                s2_m_q    <= s2_m_d;
                s2_t_q    <= s2_t_d;
                s2_sel_q  <= s1_q.select;
                s2_mode_q <= s1_q.mode;
                s2_v_q    <= s1_v_q;
            end
            if (en3) begin
                x_q    <= x_d;
                y_q    <= y_d;
                s3_v_q <= s2_v_q;
            end
        end
    end

    assign valid_o = s3_v_q;
    assign x_o     = x_q;
    assign y_o     = y_q;

endmodule

// File: tb/tb_ntt_butterfly.sv
// Scoreboard bench for ntt_butterfly: directed vectors, random stream, backpressure, reset.
module tb_ntt_butterfly;

    typedef logic [22:0] cf_t;
    typedef struct packed {
        cf_t x;
        cf_t y;
    } res_t;

    logic clk = 1'b0;
    logic rst_i, valid_i, ready_i, select_i, mode_i;
    cf_t  a_i, b_i, w_i;
    logic ready_o, valid_o;
    cf_t  x_o, y_o;

    res_t sb[$];
    int   errors   = 0;
    int   checks   = 0;
    int   captures = 0;

    always #5 clk = ~clk;

    ntt_butterfly dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .select_i (select_i),
        .mode_i   (mode_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .w_i      (w_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .x_o      (x_o),
        .y_o      (y_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference butterfly straight from the math, using wide integers and %.
    function automatic res_t model(input bit sel, input bit mode,
                                   input longint a, input longint b, input longint w);
        longint q, t, x, y;
        q = sel ? 64'd3329 : 64'd8380417;
        if (!mode) begin
            t = (w * b) % q;
            x = (a + t) % q;
            y = (a - t + q) % q;
        end else begin
            x = (a + b) % q;
            y = (((a - b + q) % q) * w) % q;
        end
        return '{x: cf_t'(x), y: cf_t'(y)};
    endfunction

    // Called just after a rising edge; returns just after the capturing edge.
    task automatic send(input bit sel, input bit mode, input cf_t a, input cf_t b,
                        input cf_t w, input res_t exp);
        int n;
        select_i = sel; mode_i = mode; a_i = a; b_i = b; w_i = w; valid_i = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (ready_o) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL send_timeout: ready_o stayed 0 for %0d cycles, expected 1", n);
                valid_i = 1'b0;
                return;
            end
        end
        sb.push_back(exp);
        @(posedge clk); #1;
        captures++;
    endtask

    task automatic send_rand();
        bit  sel, mode;
        int  q;
        cf_t a, b, w;
        sel  = 1'($urandom_range(1));
        mode = 1'($urandom_range(1));
        q    = sel ? 3329 : 8380417;
        a    = cf_t'($urandom_range(q - 1));
        b    = cf_t'($urandom_range(q - 1));
        w    = cf_t'($urandom_range(q - 1));
        send(sel, mode, a, b, w, model(sel, mode, a, b, w));
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_latency(input string tag);
        valid_i = 1'b0;
        @(negedge clk); chk({tag, "_lat0"}, 64'(valid_o), 64'd0);
        @(negedge clk); chk({tag, "_lat1"}, 64'(valid_o), 64'd0);
        @(negedge clk); chk({tag, "_lat2"}, 64'(valid_o), 64'd1);
        @(posedge clk); #1;
    endtask

    // Monitor: pops on every output transfer and checks hold-stability during stalls.
    initial begin
        bit   pst;
        res_t prev, e;
        pst = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                pst = 1'b0;
            end else begin
                if (pst) begin
                    chk("stall_valid", 64'(valid_o), 64'd1);
                    chk("stall_x", 64'(x_o), 64'(prev.x));
                    chk("stall_y", 64'(y_o), 64'(prev.y));
                end
                if (valid_o && ready_i) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_output: got x=%0d y=%0d expected no result", x_o, y_o);
                    end else begin
                        e = sb.pop_front();
                        chk("x", 64'(x_o), 64'(e.x));
                        chk("y", 64'(y_o), 64'(e.y));
                    end
                end
                pst    = valid_o && !ready_i;
                prev.x = x_o;
                prev.y = y_o;
            end
        end
    end

    initial begin
        time t0, t1;
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        select_i = 1'b0; mode_i = 1'b0; a_i = '0; b_i = '0; w_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_valid", 64'(valid_o), 64'd0);
        chk("reset_x", 64'(x_o), 64'd0);
        chk("reset_y", 64'(y_o), 64'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;

        // Directed vectors with hand-computed results.
        send(1'b0, 1'b0, 23'd1, 23'd2, 23'd3, '{x: 23'd7, y: 23'd8380412});
        check_latency("dil_ct");
        send(1'b1, 1'b0, 23'd3000, 23'd3328, 23'd3328, '{x: 23'd3001, y: 23'd2999});
        send(1'b1, 1'b0, 23'd3328, 23'd1, 23'd1, '{x: 23'd0, y: 23'd3327});
        send(1'b1, 1'b1, 23'd5, 23'd10, 23'd2, '{x: 23'd15, y: 23'd3319});
        send(1'b0, 1'b1, 23'd0, 23'd1, 23'd1, '{x: 23'd1, y: 23'd8380416});
        idle(6);

        // Back-to-back random stream, full throughput.
        t0 = $time;
        for (int i = 0; i < 20; i++) send_rand();
        t1 = $time;
        valid_i = 1'b0;
        chk("stream_cycles", 64'((t1 - t0) / 10), 64'd20);
        idle(6);

        // Backpressure: five offered, output blocked for several cycles.
        ready_i  = 1'b0;
        captures = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) send_rand();
                valid_i = 1'b0;
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_ready_low", 64'(ready_o), 64'd0);
                chk("bp_captures", 64'(captures), 64'd3);
                repeat (2) @(negedge clk);
                @(posedge clk); #1;
                ready_i = 1'b1;
            end
        join
        idle(10);

        // Reset with three transactions in flight.
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send_rand();
        valid_i = 1'b0;
        rst_i   = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(ready_o), 64'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        sb.delete();
        ready_i = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 64'(valid_o), 64'd0);
        chk("midrst_x", 64'(x_o), 64'd0);
        chk("midrst_y", 64'(y_o), 64'd0);
        @(posedge clk); #1;
        idle(5);
        send_rand();
        check_latency("post_rst");
        idle(5);

        chk("drain", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ntt_butterfly.md
Name: ntt_butterfly

Overview:
- Pipelined NTT/INTT butterfly that wraps the existing combinational mod_mul and consumes its product.
- Supports Dilithium (q=8380417) and Kyber (q=3329), selected per transaction.
- Supports Cooley-Tukey (forward NTT) and Gentleman-Sande (inverse NTT), selected per transaction.
- Sits between the coefficient memory read port and the write-back path of the NTT engine; uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 23, coefficient width. Must hold 8380416; fixed by ntt_pkg, not to be overridden.

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  input transaction present
- ready_o  out  1  block accepts input this cycle
- select_i  in  1  0 = Dilithium q=8380417, 1 = Kyber q=3329 (same encoding as mod_mul)
- mode_i  in  1  0 = CT, 1 = GS
- a_i  in  WIDTH  coefficient a, required < q
- b_i  in  WIDTH  coefficient b, required < q
- w_i  in  WIDTH  twiddle factor, required < q
- valid_o  out  1  result present
- ready_i  in  1  downstream accepts result
- x_o  out  WIDTH  first butterfly output
- y_o  out  WIDTH  second butterfly output

Behaviour:
- Transfer rules:
  - Input transfer when valid_i && ready_o at a rising edge.
  - Output transfer when valid_o && ready_i at a rising edge.
- Functions (all mod q):
  - CT: x=(a+w*b), y=(a-w*b).
  - GS: x=(a+b), y=(a-b)*w.
- Pipeline: three register stages S1, S2, S3, each with a valid bit; select/mode travel with the data.
  - S1: registered a, b, w, select, mode.
  - S2: single mod_mul instance. Multiplier operand is b for CT, (a-b) mod q for GS.
    - CT registers m=b*w and a.
    - GS registers m=(a-b)*w and s=(a+b) mod q.
  - S3:
    - CT registers x=(a+m) mod q and y=(a-m) mod q.
    - GS registers x=s and y=m.
- Latency: transaction captured at edge N appears on x_o/y_o with valid_o=1 after edge N+2 (no stall); throughput 1 per cycle.
- Flow control:
  - Stage k advances when stage k+1 is empty or advancing.
  - S3 advances when !valid_o || ready_i.
  - ready_o = !S1.valid || S1 advancing (combinational from ready_i through the valid chain). ready_o = 0 while rst_i = 1.
- Stall: while valid_o && !ready_i, x_o/y_o/valid_o hold stable. Up to 3 transactions are buffered; no loss, no reorder, no duplication.
- Modular add/sub rules:
  - Sum computed in WIDTH+1 bits; subtract q if ≥ q.
  - Difference: if a < m, result = a + q - m.
  - No % operator in RTL.
- Reset (including mid-operation): at the clocked rst_i edge all valid bits and all data registers clear to 0, so valid_o=0, x_o=0, y_o=0. In-flight transactions are discarded.
- Out-of-range inputs (≥ q): outputs unspecified but valid/ready protocol still correct.
- Simultaneous input and output transfer on a full pipeline: allowed, full throughput sustained.

Decomposition:
- ntt_pkg holds:
  - localparam WIDTH=23
  - Q_DILITHIUM=23'd8380417, Q_KYBER=23'd3329
  - typedef logic [WIDTH-1:0] coeff_t
  - enum bf_mode_e {BF_CT=1'b0, BF_GS=1'b1}
  - function q_of(select) returning coeff_t
- Sub-module mod_addsub: combinational; inputs u, v, select; outputs (u+v) mod q and (u-v) mod q. Two instances: S2 pre-add/sub for GS, S3 post-add/sub for CT.
- Existing mod_mul instantiated once in S2, unchanged.

Test Plan:
- Dilithium CT, a=1 b=2 w=3, ready_i=1 -> x_o=7, y_o=8380412, valid_o high two edges after capture.
- Kyber CT, a=3000 b=3328 w=3328 -> x_o=3001, y_o=2999. Also a=3328 b=1 w=1 -> x_o=0 (wrap), y_o=3327.
- Kyber GS, a=5 b=10 w=2 -> x_o=15, y_o=3319. Dilithium GS a=0 b=1 w=1 -> x_o=1, y_o=8380416.
- Back-to-back mixed select/mode stream of 20 random vectors with ready_i=1 -> one result per cycle, in order, matching a scoreboard model.
- Backpressure: 5 vectors offered continuously, ready_i=0 for 6 cycles -> ready_o drops after 3 captures; x_o/y_o stable while stalled; all 5 results later delivered in order.
- Reset mid-stream: assert rst_i for 1 cycle with 3 in flight -> valid_o=0, x_o=y_o=0 next edge; no stale result emerges afterwards; next vector processed with normal latency.
